ocm_ins_fetch: RTL and testbench

- CPU-side receiver for the on-chip-memory instruction-delivery protocol.
- Requests one instruction from the OCM controller with the Ready/Start handshake.
- Captures the 1-3 instruction bytes delivered by GiveIns strobes, indexed by SIns, into Opcode/Operand registers.
- Decodes the expected length from the opcode, then presents the assembled instruction to the CPU with a one-cycle InsValid pulse, or flags an error.

---
 rtl/ocm_ins_fetch.sv | 118 +++++++++++
 tb/tb_ocm_ins_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocm_ins_fetch.sv
// ocm_ins_fetch: CPU-side receiver for OCM instruction delivery; define OCM_SEQ_CHECK_EN for strict byte-order and undefined-opcode checks
module ocm_ins_fetch #(
    parameter int TIMEOUT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_fetch,
    output logic       o_busy,
    input  logic       i_ocm_ready,
    output logic       o_ocm_start,
    input  logic       i_give_ins,
    input  logic [1:0] i_s_ins,
    input  logic [7:0] i_ins_byte,
    output logic [7:0] o_opcode,
    output logic [7:0] o_operand1,
    output logic [7:0] o_operand2,
    output logic [1:0] o_ins_len,
    output logic       o_ins_valid,
    output logic       o_error,
    output logic       o_timeout
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_REQ, S_COLLECT, S_DONE, S_ERR} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_timer, r_count, w_count_inc;
    logic [7:0] r_opcode, r_operand1, r_operand2;
    logic [1:0] r_ins_len, w_dec_len, w_len;
    logic       r_error, r_timeout;
    logic       w_accept, w_strobe, w_bad_idx, w_seq_err, w_complete, w_expired;

    assign w_accept    = (r_state == S_IDLE) && i_fetch;
    assign w_strobe    = (r_state == S_COLLECT) && i_give_ins;
    assign w_bad_idx   = w_strobe && (i_s_ins == 2'd3);
    assign w_count_inc = r_count + 8'd1;
    assign w_len       = (w_strobe && i_s_ins == 2'd0) ? w_dec_len : r_ins_len;
    assign w_expired   = (r_state == S_COLLECT) && (r_timer <= 8'd1);
`ifdef OCM_SEQ_CHECK_EN
    assign w_seq_err   = w_strobe && (({6'd0, i_s_ins} != r_count) || (i_s_ins == 2'd0 && w_dec_len == 2'd0));
`else
    assign w_seq_err   = 1'b0;
`endif
    // a byte indexed beyond the decoded length can never finish the instruction
    assign w_complete  = w_strobe && !w_bad_idx && !w_seq_err && (w_len != 2'd0) &&
                         (i_s_ins < w_len) && (w_count_inc == {6'd0, w_len});

    assign o_opcode    = r_opcode;
    assign o_operand1  = r_operand1;
    assign o_operand2  = r_operand2;
    assign o_ins_len   = r_ins_len;
    assign o_error     = r_error;
    assign o_timeout   = r_timeout;

    // instruction length from the incoming opcode byte
    always_comb begin
        w_dec_len = (i_ins_byte == 8'h4A) ? 2'd3 :
                    (i_ins_byte == 8'h16 || (i_ins_byte >= 8'h41 && i_ins_byte <= 8'h46)) ? 2'd2 :
                    (i_ins_byte <= 8'h19 || (i_ins_byte >= 8'h40 && i_ins_byte <= 8'h4C) ||
                     i_ins_byte == 8'h80 || i_ins_byte == 8'h81) ? 2'd1 : 2'd0;
    end

    // next state and state-decoded outputs
    always_comb begin
        w_next      = r_state;
        o_busy      = (r_state != S_IDLE);
        o_ocm_start = (r_state == S_REQ);
        o_ins_valid = (r_state == S_DONE);
        case (r_state)
            S_IDLE:     w_next = i_fetch ? S_WAIT_RDY : S_IDLE;
            S_WAIT_RDY: w_next = i_ocm_ready ? S_REQ : S_WAIT_RDY;
            S_REQ:      w_next = S_COLLECT;
            S_COLLECT:  w_next = (w_bad_idx || w_seq_err) ? S_ERR :
                                 w_complete ? S_DONE : w_expired ? S_IDLE : S_COLLECT;
            default:    w_next = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // timer, byte capture, and sticky status flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer    <= 8'd0;
            r_count    <= 8'd0;
            r_opcode   <= 8'h00;
            r_operand1 <= 8'h00;
            r_operand2 <= 8'h00;
            r_ins_len  <= 2'd0;
            r_error    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_error    <= 1'b0;
                r_timeout  <= 1'b0;
                r_count    <= 8'd0;
                r_operand1 <= 8'h00;
                r_operand2 <= 8'h00;
            end
            if (r_state == S_REQ)
                r_timer <= 8'(TIMEOUT);
            else if (r_state == S_COLLECT && r_timer != 8'd0)
                r_timer <= r_timer - 8'd1;
            if (w_strobe && !w_bad_idx) begin
                r_count <= w_count_inc;
                if (i_s_ins == 2'd0) begin
                    r_opcode  <= i_ins_byte;
                    r_ins_len <= w_dec_len;
                end
                if (i_s_ins == 2'd1) r_operand1 <= i_ins_byte;
                if (i_s_ins == 2'd2) r_operand2 <= i_ins_byte;
            end
            if (r_state == S_COLLECT && (w_bad_idx || w_seq_err)) r_error <= 1'b1;
            if (r_state == S_COLLECT && w_next == S_IDLE) r_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ocm_ins_fetch.sv
// tb_ocm_ins_fetch: randomized transaction bench with a behavioural model of the OCM fetch receiver
module tb_ocm_ins_fetch;
    localparam int TO = 8;
    localparam logic [7:0] POOL [8] = '{8'h4A, 8'h16, 8'h43, 8'h05, 8'h80, 8'h4C, 8'h1A, 8'h3F};

    logic       clk = 1'b0, rst, fetch, ocm_ready, give_ins;
    logic [1:0] s_ins;
    logic [7:0] ins_byte;
    logic       o_busy, o_ocm_start, o_ins_valid, o_error, o_timeout;
    logic [7:0] o_opcode, o_operand1, o_operand2;
    logic [1:0] o_ins_len;

    always #5 clk = ~clk;

    ocm_ins_fetch #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_fetch(fetch), .o_busy(o_busy),
        .i_ocm_ready(ocm_ready), .o_ocm_start(o_ocm_start),
        .i_give_ins(give_ins), .i_s_ins(s_ins), .i_ins_byte(ins_byte),
        .o_opcode(o_opcode), .o_operand1(o_operand1), .o_operand2(o_operand2),
        .o_ins_len(o_ins_len), .o_ins_valid(o_ins_valid), .o_error(o_error), .o_timeout(o_timeout)
    );

    int errors = 0, checks = 0, n_start = 0;
    bit e_chk = 1'b0;
    logic e_busy, e_start, e_valid, e_err, e_to;
    logic [7:0] e_op, e_o1, e_o2;
    logic [1:0] e_len;

    logic [7:0] m_b [3];
    int  m_len, m_cnt;
    bit  m_err, m_to;

    bit         sc_g [TO];
    logic [1:0] sc_s [TO];
    logic [7:0] sc_b [TO];

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic int dec(input logic [7:0] b);
        if (b == 8'h4A) return 3;
        if (b == 8'h16 || b inside {[8'h41:8'h46]}) return 2;
        if (b inside {[8'h00:8'h19], [8'h40:8'h4C], 8'h80, 8'h81}) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (o_ocm_start) n_start++;
        if (e_chk) begin
            chk("busy", int'(o_busy), int'(e_busy));
            chk("ocm_start", int'(o_ocm_start), int'(e_start));
            chk("ins_valid", int'(o_ins_valid), int'(e_valid));
            chk("error", int'(o_error), int'(e_err));
            chk("timeout", int'(o_timeout), int'(e_to));
            chk("opcode", int'(o_opcode), int'(e_op));
            chk("operand1", int'(o_operand1), int'(e_o1));
            chk("operand2", int'(o_operand2), int'(e_o2));
            chk("ins_len", int'(o_ins_len), int'(e_len));
        end
    end

    task automatic model_reset();
        m_b[0] = 8'h00; m_b[1] = 8'h00; m_b[2] = 8'h00;
        m_len = 0; m_cnt = 0; m_err = 1'b0; m_to = 1'b0;
    endtask

    task automatic cyc(input bit f, input bit r, input bit g, input logic [1:0] s, input logic [7:0] b);
        @(posedge clk); #1;
        fetch = f; ocm_ready = r; give_ins = g; s_ins = s; ins_byte = b;
    endtask

    task automatic expect_out(input bit busy, input bit start, input bit valid);
        e_busy = busy; e_start = start; e_valid = valid; e_err = m_err; e_to = m_to;
        e_op = m_b[0]; e_o1 = m_b[1]; e_o2 = m_b[2]; e_len = 2'(m_len);
    endtask

    task automatic noisy(input bit busy, input bit start, input bit valid);
        cyc(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
        expect_out(busy, start, valid);
    endtask

    task automatic idle_cycle();
        cyc(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
        expect_out(1'b0, 1'b0, 1'b0);
    endtask

    // res: 1 completed, 2 error, 3 timeout
    task automatic run_txn(input int rdy_delay, output int res);
        int s, len_now;
        bit bad;
        cyc(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
        expect_out(1'b0, 1'b0, 1'b0);
        m_err = 1'b0; m_to = 1'b0; m_cnt = 0; m_b[1] = 8'h00; m_b[2] = 8'h00;
        for (int i = 0; i < rdy_delay; i++) begin
            cyc(1'($urandom), 1'b0, 1'($urandom), 2'($urandom), 8'($urandom));
            expect_out(1'b1, 1'b0, 1'b0);
        end
        cyc(1'($urandom), 1'b1, 1'($urandom), 2'($urandom), 8'($urandom));
        expect_out(1'b1, 1'b0, 1'b0);
        noisy(1'b1, 1'b1, 1'b0);
        res = 0;
        for (int t = 1; t <= TO && res == 0; t++) begin
            cyc(1'($urandom), 1'($urandom), sc_g[t-1], sc_s[t-1], sc_b[t-1]);
            expect_out(1'b1, 1'b0, 1'b0);
            if (sc_g[t-1]) begin
                s = int'(sc_s[t-1]);
                len_now = (s == 0) ? dec(sc_b[t-1]) : m_len;
                bad = (s == 3);
`ifdef OCM_SEQ_CHECK_EN
                bad = bad || (s != m_cnt) || (s == 0 && len_now == 0);
`endif
                if (s != 3) begin
                    m_b[s] = sc_b[t-1];
                    if (s == 0) m_len = len_now;
                    m_cnt++;
                end
                if (bad) res = 2;
                else if (len_now != 0 && s < len_now && m_cnt == len_now) res = 1;
            end
            if (res == 0 && t == TO) res = 3;
        end
        if (res == 1) noisy(1'b1, 1'b0, 1'b1);
        if (res == 2) begin
            m_err = 1'b1;
            noisy(1'b1, 1'b0, 1'b0);
        end
        if (res == 3) m_to = 1'b1;
    endtask

    task automatic clear_script();
        for (int i = 0; i < TO; i++) begin
            sc_g[i] = 1'b0; sc_s[i] = 2'd0; sc_b[i] = 8'h00;
        end
    endtask

    task automatic put(input int t, input logic [1:0] s, input logic [7:0] b);
        sc_g[t-1] = 1'b1; sc_s[t-1] = s; sc_b[t-1] = b;
    endtask

    task automatic gen_script();
        int p, l, mode, first, last;
        logic [7:0] op;
        clear_script();
        op = ($urandom_range(0, 1) == 1) ? 8'($urandom) : POOL[$urandom_range(0, 7)];
        l = (dec(op) == 0) ? 1 : dec(op);
        mode = $urandom_range(0, 9);
        p = $urandom_range(0, 2);
        first = p; last = p;
        for (int k = 0; k < l; k++) begin
            sc_g[p] = 1'b1; sc_s[p] = 2'(k); sc_b[p] = (k == 0) ? op : 8'($urandom);
            last = p;
            p += 1 + $urandom_range(0, 1);
        end
        if (mode == 0) sc_s[first] = 2'd3;
        if (mode == 1) sc_g[last] = 1'b0;
        if (mode == 2) for (int i = 0; i < TO; i++) sc_s[i] = 2'($urandom);
        if (mode == 3) begin
            sc_g[TO-1] = 1'b1; sc_s[TO-1] = 2'($urandom); sc_b[TO-1] = 8'($urandom);
        end
    endtask

    initial begin
        int res, s0;
        rst = 1'b1; fetch = 1'b0; ocm_ready = 1'b0; give_ins = 1'b0; s_ins = 2'd0; ins_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        expect_out(1'b0, 1'b0, 1'b0);
        e_chk = 1'b1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_start", int'(o_ocm_start), 0);
        chk("rst_valid", int'(o_ins_valid), 0);
        chk("rst_opcode", int'(o_opcode), 8'h00);
        chk("rst_len", int'(o_ins_len), 0);
        chk("rst_error", int'(o_error), 0);
        chk("rst_timeout", int'(o_timeout), 0);

        // reset while collecting a 3-byte instruction
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'h00); expect_out(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'h00); expect_out(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00); expect_out(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 8'h4A); expect_out(1'b1, 1'b0, 1'b0);
        m_b[0] = 8'h4A; m_len = 3; m_cnt = 1;
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00); expect_out(1'b1, 1'b0, 1'b0);
        chk("mid_opcode", int'(o_opcode), 8'h4A);
        chk("mid_len", int'(o_ins_len), 3);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        rst = 1'b0;
        model_reset();
        expect_out(1'b0, 1'b0, 1'b0);
        chk("rst2_busy", int'(o_busy), 0);
        chk("rst2_opcode", int'(o_opcode), 8'h00);
        chk("rst2_len", int'(o_ins_len), 0);
        chk("rst2_valid", int'(o_ins_valid), 0);

        // one-byte instruction two cycles after OcmStart
        clear_script(); put(2, 2'd0, 8'h05);
        run_txn(0, res);
        chk("t2_valid", int'(o_ins_valid), 1);
        chk("t2_opcode", int'(o_opcode), 8'h05);
        chk("t2_len", int'(o_ins_len), 1);
        idle_cycle();
        chk("t2_busy_after", int'(o_busy), 0);

        // three-byte instruction on consecutive cycles
        clear_script(); put(1, 2'd0, 8'h4A); put(2, 2'd1, 8'h12); put(3, 2'd2, 8'h34);
        run_txn(0, res);
        chk("t3_valid", int'(o_ins_valid), 1);
        chk("t3_opcode", int'(o_opcode), 8'h4A);
        chk("t3_op1", int'(o_operand1), 8'h12);
        chk("t3_op2", int'(o_operand2), 8'h34);
        chk("t3_len", int'(o_ins_len), 3);
        idle_cycle();
        chk("t3_single_valid", int'(o_ins_valid), 0);

        // OCM not ready for five cycles
        s0 = n_start;
        clear_script(); put(1, 2'd0, 8'h80);
        run_txn(5, res);
        chk("t4_start_pulses", n_start - s0, 1);
        idle_cycle();

        // two-byte opcode with its operand never delivered
        clear_script(); put(1, 2'd0, 8'h43);
        run_txn(0, res);
        idle_cycle();
        chk("t5_timeout", int'(o_timeout), 1);
        chk("t5_no_valid", int'(o_ins_valid), 0);
        clear_script(); put(1, 2'd0, 8'h05);
        run_txn(1, res);
        chk("t5_timeout_cleared", int'(o_timeout), 0);
        idle_cycle();

        // opcode 16 followed by a skipped operand index
        clear_script(); put(1, 2'd0, 8'h16); put(2, 2'd2, 8'h99);
        run_txn(0, res);
`ifdef OCM_SEQ_CHECK_EN
        chk("t6_error", int'(o_error), 1);
        chk("t6_no_valid", int'(o_ins_valid), 0);
        idle_cycle();
`else
        idle_cycle();
        chk("t6_timeout", int'(o_timeout), 1);
        chk("t6_no_error", int'(o_error), 0);
`endif

        for (int n = 0; n < 300; n++) begin
            gen_script();
            run_txn($urandom_range(0, 3), res);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();
        @(posedge clk);
        e_chk = 1'b0;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
